logic_unit_arbiter: RTL and testbench

//   Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters.

---
 rtl/logic_unit_arbiter.sv | 116 +++++++++++
 tb/tb_logic_unit_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two
//   requesters. Arbitration is round-robin. The result is held in a register,
//   and every interface uses a valid/ready handshake.
//
// Ports
//   clock, reset_n          rising-edge clock, async active-low reset
//   reqN_valid/ready        requester N handshake (N = 0,1); ready is combinational
//   reqN_op/opA/opB         op (00 AND, 01 OR, 10 XOR, 11 NOR) and operands
//   res_valid/ready         result handshake toward the consumer
//   res_data, res_id        registered result and the requester that issued it
//   busy                    mirrors res_valid
//   op_count                completed result handshakes, wraps at 2^CNT_W
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_opA,
  input  logic [WIDTH-1:0] req0_opB,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_opA,
  input  logic [WIDTH-1:0] req1_opB,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
  } req_t;

  req_t             sel;
  logic             slot_free, res_fire, gnt_vld, gnt_id, accept;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  function automatic logic [WIDTH-1:0] lu_eval(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   lu_eval = a & b;
      2'b01:   lu_eval = a | b;
      2'b10:   lu_eval = a ^ b;
      default: lu_eval = ~(a | b);
    endcase
  endfunction

  always_comb begin
    slot_free = !res_valid_q | res_ready;
    res_fire  = res_valid_q & res_ready;
    gnt_vld   = req0_valid | req1_valid;
    // Under contention the priority pointer decides; otherwise whoever is valid.
    gnt_id    = (req0_valid & req1_valid) ? prio_q : req1_valid;
    // Readies are gated by reset_n so nothing is accepted while reset is held.
    accept     = gnt_vld & slot_free & reset_n;
    req0_ready = accept & ~gnt_id;
    req1_ready = accept & gnt_id;

    sel = gnt_id ? req_t'{req1_op, req1_opA, req1_opB}
                 : req_t'{req0_op, req0_opA, req0_opB};

    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    prio_d      = prio_q;
    if (accept) begin
      // An accept may coincide with a result handshake: the slot is refilled
      // in the same cycle, so one op per cycle can be sustained.
      res_valid_d = 1'b1;
      res_data_d  = lu_eval(sel.op, sel.opa, sel.opb);
      res_id_d    = gnt_id;
      prio_d      = ~gnt_id;
    end else if (res_fire) begin
      res_valid_d = 1'b0;
    end
    op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, res_fire};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      prio_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      prio_q      <= prio_d;
      op_count_q  <= op_count_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = res_valid_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_opA = '0, req0_opB = '0, req1_opA = '0, req1_opB = '0;
  logic        res_ready = 1'b0;

  logic        req0_ready, req1_ready, res_valid, res_id, busy;
  logic [31:0] res_data;
  logic [15:0] op_count;

  logic        c_req0_ready, c_req1_ready, c_res_valid, c_res_id, c_busy;
  logic [31:0] c_res_data;
  logic [3:0]  c_op_count;

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 clock = ~clock;

  logic_unit_arbiter #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_opA(req0_opA), .req0_opB(req0_opB),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_opA(req1_opA), .req1_opB(req1_opB),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy), .op_count(op_count)
  );

  // Same stimulus, narrow counter, to exercise the wrap.
  logic_unit_arbiter #(.WIDTH(32), .CNT_W(4)) u_dut_c4 (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(c_req0_ready), .req0_op(req0_op),
    .req0_opA(req0_opA), .req0_opB(req0_opB),
    .req1_valid(req1_valid), .req1_ready(c_req1_ready), .req1_op(req1_op),
    .req1_opA(req1_opA), .req1_opB(req1_opB),
    .res_valid(c_res_valid), .res_ready(res_ready), .res_data(c_res_data),
    .res_id(c_res_id), .busy(c_busy), .op_count(c_op_count)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req0_valid = 1'b1; res_ready = 1'b1;
    #1;
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %h exp 0", res_valid); end
    n_chk++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL reset_res_data got %h exp 0", res_data); end
    n_chk++; if (op_count !== 16'h0) begin n_fail++; $display("FAIL reset_op_count got %h exp 0", op_count); end
    n_chk++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready got %h exp 0", req0_ready); end
    tick;
    req0_valid = 1'b0; res_ready = 1'b0;
    reset_n = 1'b1;
    tick;
    exp_cnt = 0;
  endtask

  task automatic test_single_op;
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b01; req0_opA = 32'hF0F0_0000; req0_opB = 32'h0000_0F0F;
    #1;
    n_chk++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_req0_ready got %h exp 1", req0_ready); end
    n_chk++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_req1_ready got %h exp 0", req1_ready); end
    tick;
    req0_valid = 1'b0;
    n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_res_valid got %h exp 1", res_valid); end
    n_chk++; if (res_data !== 32'hF0F0_0F0F) begin n_fail++; $display("FAIL single_res_data got %h exp f0f00f0f", res_data); end
    n_chk++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL single_res_id got %h exp 0", res_id); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %h exp 1", busy); end
    tick; exp_cnt++;
    n_chk++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL single_op_count got %0d exp 1", op_count); end
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_res_drain got %h exp 0", res_valid); end
  endtask

  // Leaves prio pointing at requester 0 (last accept is requester 1).
  task automatic test_backpressure;
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_opA = 32'hFFFF_0000; req0_opB = 32'hFF00_FF00;
    #1;
    n_chk++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_req0_ready got %h exp 1", req0_ready); end
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b10; req1_opA = 32'h1234_5678; req1_opB = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req1_ready[%0d] got %h exp 0", i, req1_ready); end
      n_chk++; if (res_data !== 32'hFF00_0000) begin n_fail++; $display("FAIL bp_hold_data[%0d] got %h exp ff000000", i, res_data); end
      n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d] got %h exp 1", i, res_valid); end
      tick;
    end
    res_ready = 1'b1;
    #1;
    n_chk++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %h exp 1", req1_ready); end
    tick; exp_cnt++;
    req1_valid = 1'b0;
    n_chk++; if (res_data !== 32'hEDCB_A987) begin n_fail++; $display("FAIL bp_next_data got %h exp edcba987", res_data); end
    n_chk++; if (res_id !== 1'b1) begin n_fail++; $display("FAIL bp_next_id got %h exp 1", res_id); end
    tick; exp_cnt++;
    n_chk++; if (op_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_op_count got %0d exp %0d", op_count, exp_cnt); end
  endtask

  task automatic test_contention;
    logic [31:0] exp_d [2];
    exp_d[0] = 32'h0F0F_0000;
    exp_d[1] = 32'h0000_00FF;
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b00; req0_opA = 32'hFFFF_0000; req0_opB = 32'h0F0F_0F0F;
    req1_valid = 1'b1; req1_op = 2'b01; req1_opA = 32'h0000_00F0; req1_opB = 32'h0000_000F;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if ({req1_ready, req0_ready} !== ((i % 2) ? 2'b10 : 2'b01))
        begin n_fail++; $display("FAIL cont_ready[%0d] got %b exp %b", i, {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01); end
      if (i > 0) exp_cnt++;
      tick;
      n_chk++; if (res_id !== 1'(i % 2)) begin n_fail++; $display("FAIL cont_id[%0d] got %h exp %0d", i, res_id, i % 2); end
      n_chk++; if (res_data !== exp_d[i % 2]) begin n_fail++; $display("FAIL cont_data[%0d] got %h exp %h", i, res_data, exp_d[i % 2]); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick; exp_cnt++;
    n_chk++; if (op_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL cont_op_count got %0d exp %0d", op_count, exp_cnt); end
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL cont_drain got %h exp 0", res_valid); end
  endtask

  task automatic test_ops;
    logic [1:0]  ops  [4];
    logic [31:0] exps [4];
    ops[0] = 2'b00; exps[0] = 32'hFF00_0000;
    ops[1] = 2'b10; exps[1] = 32'h00FF_FF00;
    ops[2] = 2'b11; exps[2] = 32'h0000_00FF;
    ops[3] = 2'b01; exps[3] = 32'hFFFF_FF00;
    res_ready = 1'b1;
    req1_valid = 1'b1; req1_opA = 32'hFFFF_0000; req1_opB = 32'hFF00_FF00;
    for (int i = 0; i < 4; i++) begin
      req1_op = ops[i];
      if (i > 0) exp_cnt++;
      tick;
      n_chk++; if (res_data !== exps[i]) begin n_fail++; $display("FAIL ops_data[%0d] got %h exp %h", i, res_data, exps[i]); end
    end
    req1_valid = 1'b0;
    tick; exp_cnt++;
    n_chk++; if (op_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL ops_op_count got %0d exp %0d", op_count, exp_cnt); end
  endtask

  task automatic test_counter_wrap;
    reset_n = 1'b0; #2; reset_n = 1'b1;
    tick;
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b10; req0_opB = 32'h0;
    for (int i = 0; i < 17; i++) begin
      req0_opA = 32'(i);
      tick;
      // i completed results before this edge's refill -> i handshakes so far
      if (i == 16) begin
        n_chk++; if (c_op_count !== 4'd0) begin n_fail++; $display("FAIL wrap_at16 got %0d exp 0", c_op_count); end
      end
    end
    req0_valid = 1'b0;
    n_chk++; if (res_data !== 32'd16) begin n_fail++; $display("FAIL wrap_last_data got %h exp 10", res_data); end
    tick;
    n_chk++; if (c_op_count !== 4'd1) begin n_fail++; $display("FAIL wrap_c4_count got %0d exp 1", c_op_count); end
    n_chk++; if (op_count !== 16'd17) begin n_fail++; $display("FAIL wrap_c16_count got %0d exp 17", op_count); end
  endtask

  task automatic test_reset_mid;
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_opA = 32'hFFFF_FFFF; req0_opB = 32'hA5A5_A5A5;
    tick;
    n_chk++; if (res_data !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mid_pending_data got %h exp a5a5a5a5", res_data); end
    req1_valid = 1'b1; res_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_res_valid got %h exp 0", res_valid); end
    n_chk++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL mid_res_data got %h exp 0", res_data); end
    n_chk++; if (op_count !== 16'h0) begin n_fail++; $display("FAIL mid_op_count got %0d exp 0", op_count); end
    n_chk++; if (c_op_count !== 4'h0) begin n_fail++; $display("FAIL mid_op_count_c4 got %0d exp 0", c_op_count); end
    n_chk++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_readies got %b exp 00", {req1_ready, req0_ready}); end
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_n = 1'b1;
    tick;
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_replay got %h exp 0", res_valid); end
  endtask

  initial begin
    test_reset;
    test_single_op;
    test_backpressure;
    test_contention;
    test_ops;
    test_counter_wrap;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
